// File: rtl/cpu_boot_sequencer_if.sv
// cpu_boot_sequencer_if
// Bundles the host-facing control signals, the program byte stream and the
// CPU load/enable port of the boot sequencer.
//   start, len, run_cycles  : host -> sequencer, sequence request
//   in_valid, in_data       : byte source -> sequencer
//   in_ready                : sequencer -> byte source
//   mem_load, mem_data,
//   mem_address, cpu_en     : sequencer -> CPU
//   busy, done              : sequencer -> host status
// master = host/harness side, slave = sequencer side.
interface cpu_boot_sequencer_if #(
    parameter int WORDSIZE       = 8,
    parameter int MEMADDRESSSIZE = 8,
    parameter int RUNCNTSIZE     = 16
);
    logic                      start;
    logic [MEMADDRESSSIZE-1:0] len;
    logic [RUNCNTSIZE-1:0]     run_cycles;
    logic                      in_valid;
    logic [WORDSIZE-1:0]       in_data;
    logic                      in_ready;
    logic                      mem_load;
    logic [WORDSIZE-1:0]       mem_data;
    logic [MEMADDRESSSIZE-1:0] mem_address;
    logic                      cpu_en;
    logic                      busy;
    logic                      done;

    modport master (
        output start, len, run_cycles, in_valid, in_data,
        input  in_ready, mem_load, mem_data, mem_address, cpu_en, busy, done
    );

    modport slave (
        input  start, len, run_cycles, in_valid, in_data,
        output in_ready, mem_load, mem_data, mem_address, cpu_en, busy, done
    );
endinterface

// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer
// Sequences the 8-bit stack CPU through a load phase (program image streamed
// from a valid/ready byte source into CPU memory) and a run phase (cpu_en held
// for a programmed number of cycles), then pulses done.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   step  (only with CPU_BOOT_SEQUENCER_STEP_EN) single-step request
//   bus   cpu_boot_sequencer_if.slave: start/len/run_cycles, in_valid/in_data/
//         in_ready, mem_load/mem_data/mem_address, cpu_en, busy, done
// Build option: define CPU_BOOT_SEQUENCER_STEP_EN to make RUN issue one cpu_en
// pulse per sampled step instead of enabling continuously.
// All outputs are registered except in_ready, which decodes the LOAD state.
module cpu_boot_sequencer #(
    parameter int WORDSIZE       = 8,
    parameter int MEMADDRESSSIZE = 8,
    parameter int RUNCNTSIZE     = 16
)(
    input logic clk,
    input logic rst,
`ifdef CPU_BOOT_SEQUENCER_STEP_EN
    input logic step,
`endif
    cpu_boot_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;

    localparam logic [MEMADDRESSSIZE:0] BYTE_ONE = 1;
    localparam logic [RUNCNTSIZE-1:0]   RUN_ONE  = 1;

    state_t                    state, state_n;
    logic [MEMADDRESSSIZE-1:0] len_q, len_n;
    logic [RUNCNTSIZE-1:0]     rc_q, rc_n;
    // One bit wider than an address so the index never aliases len.
    logic [MEMADDRESSSIZE:0]   byte_cnt, byte_cnt_n;
    logic [RUNCNTSIZE-1:0]     run_cnt, run_cnt_n;
    logic                      mem_load_q, mem_load_n;
    logic [WORDSIZE-1:0]       mem_data_q, mem_data_n;
    logic [MEMADDRESSSIZE-1:0] mem_address_q, mem_address_n;
    logic                      cpu_en_q, cpu_en_n;
    logic                      busy_q, done_q;
    logic [MEMADDRESSSIZE:0]   last_index;

    assign last_index = {1'b0, len_q} - BYTE_ONE;

    // State and output registers; reset clears everything including counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len_q         <= '0;
            rc_q          <= '0;
            byte_cnt      <= '0;
            run_cnt       <= '0;
            mem_load_q    <= 1'b0;
            mem_data_q    <= '0;
            mem_address_q <= '0;
            cpu_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_n;
            len_q         <= len_n;
            rc_q          <= rc_n;
            byte_cnt      <= byte_cnt_n;
            run_cnt       <= run_cnt_n;
            mem_load_q    <= mem_load_n;
            mem_data_q    <= mem_data_n;
            mem_address_q <= mem_address_n;
            cpu_en_q      <= cpu_en_n;
            // busy/done are computed from the next state so they line up
            // with the state they describe.
            busy_q        <= (state_n != IDLE);
            done_q        <= (state_n == DONE);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        len_n         = len_q;
        rc_n          = rc_q;
        byte_cnt_n    = byte_cnt;
        run_cnt_n     = run_cnt;
        mem_load_n    = 1'b0;
        mem_data_n    = mem_data_q;
        mem_address_n = mem_address_q;
        cpu_en_n      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    len_n      = bus.len;
                    rc_n       = bus.run_cycles;
                    byte_cnt_n = '0;
                    run_cnt_n  = '0;
                    state_n    = (bus.len != '0) ? LOAD : SETTLE;
                end
            end
            LOAD: begin
                // in_ready is high throughout LOAD, so valid alone is an accept.
                if (bus.in_valid) begin
                    mem_load_n    = 1'b1;
                    mem_data_n    = bus.in_data;
                    mem_address_n = byte_cnt[MEMADDRESSSIZE-1:0];
                    byte_cnt_n    = byte_cnt + BYTE_ONE;
                    if (byte_cnt == last_index) begin
                        state_n = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // The final byte's mem_load is on the wire this cycle; the
                // CPU finishes its load-time reset before enable rises.
                run_cnt_n = '0;
                if (rc_q != '0) begin
                    state_n = RUN;
`ifndef CPU_BOOT_SEQUENCER_STEP_EN
                    cpu_en_n = 1'b1;
`endif
                end else begin
                    state_n = DONE;
                end
            end
            RUN: begin
`ifdef CPU_BOOT_SEQUENCER_STEP_EN
                // run_cnt counts pulses issued; leave once the last one is out.
                if (run_cnt == rc_q) begin
                    state_n = DONE;
                end else if (step) begin
                    cpu_en_n  = 1'b1;
                    run_cnt_n = run_cnt + RUN_ONE;
                end
`else
                if (run_cnt == rc_q - RUN_ONE) begin
                    state_n = DONE;
                end else begin
                    cpu_en_n  = 1'b1;
                    run_cnt_n = run_cnt + RUN_ONE;
                end
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready    = (state == LOAD);
    assign bus.mem_load    = mem_load_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_address = mem_address_q;
    assign bus.cpu_en      = cpu_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// tb_cpu_boot_sequencer
// Directed bench for cpu_boot_sequencer: back-to-back and gapped loads,
// empty image, zero run budget, reset mid-run, and (with
// CPU_BOOT_SEQUENCER_STEP_EN) step-driven enable pulses.
module tb_cpu_boot_sequencer;
    logic clk = 1'b0;
    logic rst;
`ifdef CPU_BOOT_SEQUENCER_STEP_EN
    logic step;
`endif
    int total = 0;
    int bad = 0;
    int writes = 0;
    logic [7:0] img [4];

    cpu_boot_sequencer_if bus();

    cpu_boot_sequencer dut (
        .clk (clk),
        .rst (rst),
`ifdef CPU_BOOT_SEQUENCER_STEP_EN
        .step(step),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares all outputs at once: {in_ready, mem_load, mem_data, mem_address, cpu_en, busy, done}.
    task automatic expectOut(input string tag, input logic r, input logic l,
                             input logic [7:0] d, input logic [7:0] a,
                             input logic e, input logic b, input logic dn);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = {11'd0, bus.in_ready, bus.mem_load, bus.mem_data, bus.mem_address,
               bus.cpu_en, bus.busy, bus.done};
        exp = {11'd0, r, l, d, a, e, b, dn};
        if (bus.mem_load === 1'b1) writes++;
        checkOutput(tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] ln, input logic [15:0] rc,
                                 input logic v, input logic [7:0] d);
        bus.start      = s;
        bus.len        = ln;
        bus.run_cycles = rc;
        bus.in_valid   = v;
        bus.in_data    = d;
    endtask

    // Walks through RUN expecting cpu_en high for n cycles; a stray start
    // pulse in the middle must be ignored.
    task automatic runPhase(input string tag, input int n, input logic [7:0] d, input logic [7:0] a);
`ifdef CPU_BOOT_SEQUENCER_STEP_EN
        tick();
        expectOut({tag, "_first"}, 1'b0, 1'b0, d, a, 1'b0, 1'b1, 1'b0);
`endif
        for (int i = 0; i < n; i++) begin
            bus.start = (i == 2);
            tick();
            expectOut(tag, 1'b0, 1'b0, d, a, 1'b1, 1'b1, 1'b0);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        img = '{8'h00, 8'h05, 8'h60, 8'h30};
`ifdef CPU_BOOT_SEQUENCER_STEP_EN
        step = 1'b1;
`endif
        rst = 1'b1;
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 8'h00);
        tick();
        tick();
        expectOut("reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expectOut("idle", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Back-to-back load of 4 bytes, 10 run cycles.
        applyStimulus(1'b1, 8'd4, 16'd10, 1'b0, 8'h00);
        tick();
        bus.start = 1'b0;
        expectOut("t1_load_entry", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            tick();
            expectOut("t1_write", (i < 3), 1'b1, img[i], 8'(i), 1'b0, 1'b1, 1'b0);
        end
        bus.in_valid = 1'b0;
        runPhase("t1_run", 10, 8'h30, 8'h03);
        tick();
        expectOut("t1_done", 1'b0, 1'b0, 8'h30, 8'h03, 1'b0, 1'b1, 1'b1);
        tick();
        expectOut("t1_idle", 1'b0, 1'b0, 8'h30, 8'h03, 1'b0, 1'b0, 1'b0);

        // Gapped load: valid toggles 1,0,1,0...; data/address hold in gaps.
        writes = 0;
        applyStimulus(1'b1, 8'd4, 16'd1, 1'b0, 8'h00);
        tick();
        bus.start = 1'b0;
        expectOut("t2_load_entry", 1'b1, 1'b0, 8'h30, 8'h03, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.in_data  = (k % 2 == 0) ? img[k / 2] : 8'hEE;
            tick();
            expectOut("t2_gap", (k != 6), (k % 2 == 0), img[k / 2], 8'(k / 2), 1'b0, 1'b1, 1'b0);
        end
        bus.in_valid = 1'b0;
        runPhase("t2_run", 1, 8'h30, 8'h03);
        tick();
        expectOut("t2_done", 1'b0, 1'b0, 8'h30, 8'h03, 1'b0, 1'b1, 1'b1);
        tick();
        expectOut("t2_idle", 1'b0, 1'b0, 8'h30, 8'h03, 1'b0, 0, 1'b0);
        checkOutput("t2_write_count", 32'(writes), 32'd4);

        // Empty image: straight to SETTLE, valid data offered must be ignored.
        applyStimulus(1'b1, 8'd0, 16'd3, 1'b1, 8'hAA);
        tick();
        bus.start = 1'b0;
        expectOut("t3_settle", 1'b0, 1'b0, 8'h30, 8'h03, 1'b0, 1'b1, 1'b0);
        runPhase("t3_run", 3, 8'h30, 8'h03);
        tick();
        expectOut("t3_done", 1'b0, 1'b0, 8'h30, 8'h03, 1'b0, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        tick();
        expectOut("t3_idle", 1'b0, 1'b0, 8'h30, 8'h03, 1'b0, 1'b0, 1'b0);

        // Zero run budget: load 2 bytes, SETTLE, DONE; start during DONE ignored.
        applyStimulus(1'b1, 8'd2, 16'd0, 1'b0, 8'h00);
        tick();
        bus.start = 1'b0;
        expectOut("t4_load_entry", 1'b1, 1'b0, 8'h30, 8'h03, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        tick();
        expectOut("t4_write0", 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0);
        bus.in_data  = 8'h22;
        tick();
        expectOut("t4_settle", 1'b0, 1'b1, 8'h22, 8'h01, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        expectOut("t4_done", 1'b0, 1'b0, 8'h22, 8'h01, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'd5, 16'd5, 1'b0, 8'h00);
        tick();
        expectOut("t4_start_in_done", 1'b0, 1'b0, 8'h22, 8'h01, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick();
        expectOut("t4_stay_idle", 1'b0, 1'b0, 8'h22, 8'h01, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of RUN, then a fresh sequence from address 0.
        applyStimulus(1'b1, 8'd1, 16'd10, 1'b0, 8'h00);
        tick();
        bus.start = 1'b0;
        expectOut("t5_load_entry", 1'b1, 1'b0, 8'h22, 8'h01, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        tick();
        expectOut("t5_settle", 1'b0, 1'b1, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        runPhase("t5_run", 6, 8'h77, 8'h00);
        rst = 1'b1;
        tick();
        expectOut("t5_reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 8'd2, 16'd1, 1'b0, 8'h00);
        tick();
        bus.start = 1'b0;
        expectOut("t5_reload_entry", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h9A;
        tick();
        expectOut("t5_reload0", 1'b1, 1'b1, 8'h9A, 8'h00, 1'b0, 1'b1, 1'b0);
        bus.in_data  = 8'hBC;
        tick();
        expectOut("t5_reload1", 1'b0, 1'b1, 8'hBC, 8'h01, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        runPhase("t5_rerun", 1, 8'hBC, 8'h01);
        tick();
        expectOut("t5_done", 1'b0, 1'b0, 8'hBC, 8'h01, 1'b0, 1'b1, 1'b1);
        tick();
        expectOut("t5_idle", 1'b0, 1'b0, 8'hBC, 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef CPU_BOOT_SEQUENCER_STEP_EN
        // Step mode: steps at RUN cycles 0, 4, 9 give pulses at 1, 5, 10.
        step = 1'b0;
        applyStimulus(1'b1, 8'd0, 16'd3, 1'b0, 8'h00);
        tick();
        bus.start = 1'b0;
        expectOut("t6_settle", 1'b0, 1'b0, 8'hBC, 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 11; c++) begin
            expectOut("t6_run", 1'b0, 1'b0, 8'hBC, 8'h01, (c == 1 || c == 5 || c == 10), 1'b1, 1'b0);
            step = (c == 0 || c == 4 || c == 9);
            tick();
        end
        step = 1'b0;
        expectOut("t6_done", 1'b0, 1'b0, 8'hBC, 8'h01, 1'b0, 1'b1, 1'b1);
        tick();
        expectOut("t6_idle", 1'b0, 1'b0, 8'hBC, 8'h01, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
